idex_hazard_reg: RTL and testbench
==================================

// Module: idex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core.
//  Captures decoded operands and control from ID and presents IDEX_rs/IDEX_rt to the forwarding unit.
//  Presents EX-stage data and control to the ALU/operand muxes.
//  On a load-use dependence it stalls PC and IF/ID for one cycle and inserts a bubble into EX.
// PARAMETERS
//  DATA_W    32   width of register-file operands and sign-extended immediate
//  CNT_W     16   width of the saturating stall-event counter
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous reset, active-high
//  hold_i         in   1       external freeze (memory wait); IDEX contents held unchanged
//  flush_i        in   1       branch/jump taken; bubble loaded into IDEX
//  ID_rs, ID_rt   in   5       source register numbers decoded in ID
//  ID_rd          in   5       destination field (rd) decoded in ID
//  ID_use_rt      in   1       instruction reads rt as a source (R-type, beq, sw)
//  ID_data1/2     in   DATA_W  register-file read data for rs/rt
//  ID_imm         in   DATA_W  sign-extended immediate
//  ID_ctrl        in   8       {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp[1:0]}
//  IDEX_rs/rt/rd  out  5       registered register numbers to EX and forwarding unit
//  IDEX_data1/2   out  DATA_W  registered operands
//  IDEX_imm       out  DATA_W  registered immediate
//  IDEX_ctrl      out  8       registered control, same bit order as ID_ctrl
//  stall_o        out  1       combinational; hold PC and IF/ID this cycle
//  stall_cnt_o    out  CNT_W   count of load-use bubbles inserted, saturating
// BEHAVIOUR
//  Reset (async, rst_i=1): all IDEX_* outputs = 0, stall_cnt_o = 0; the pipeline holds a NOP.
//  Hazard (comb): haz = IDEX_ctrl[MemRead] && IDEX_rt!=0 &&
//    (IDEX_rt==ID_rs || (ID_use_rt && IDEX_rt==ID_rt)).
//  stall_o = haz | hold_i.
//  Per rising edge, priority order:
//   1. hold_i=1: every IDEX_* register holds its value; stall_cnt_o unchanged.
//   2. flush_i=1: IDEX_ctrl <- 0. Reg numbers/data are loaded from ID and are don't-care.
//      A flush overrides a coincident hazard; no count increment.
//   3. haz=1: IDEX_ctrl <- 0 (bubble); stall_cnt_o += 1 unless already all-ones.
//   4. otherwise: all IDEX_* <- ID_* (normal advance).
//  Latency: one cycle ID->EX. A load-use stall lasts exactly one cycle.
//  After the bubble, IDEX MemRead=0, so haz deasserts.
//  The held ID instruction advances on the next edge. The forwarding unit then supplies the load
//  value via MEM/WB.
//  Once the bubble is in EX, the load sits in MEM. EX/MEM forwarding must not select it: the bubble
//  has RegWrite=0 and the load has not yet produced data at EX/MEM.
//  Register $0 never triggers a hazard. Back-to-back loads to the same rt stall once per dependent
//  consumer.
//  Bubble: only IDEX_ctrl is zeroed; rs/rt/rd/data may hold stale values.
//  Consumers gate on ctrl.
//  Counter saturates at 2^CNT_W-1; it is not reset by flush, only by rst_i.
//  rst_i asserted mid-stall: outputs clear immediately.
//  stall_o follows from the cleared IDEX_ctrl, deasserting unless hold_i=1.
// TESTING
//  lw $2,0($1); add $3,$2,$4 -> stall_o=1 one cycle, IDEX_ctrl=0 next, add enters EX a cycle later.
//  lw $0,0($1); add $3,$0,$4 -> stall_o=0, stall_cnt_o stays 0.
//  lw $5; sw $6,0($5) with ID_use_rt=0 and rs=5 -> stall.
//  lw $5; addi $7,$8,1 with ID_rt=5, ID_use_rt=0 -> no stall.
//  Hazard and flush_i in the same cycle -> IDEX_ctrl=0, stall_cnt_o unchanged.
//  Hazard during hold_i=1 -> IDEX unchanged while hold.
//  After hold drops: one bubble, count +1.
//  CNT_W=2, force 5 hazards -> stall_cnt_o=3.
//  Pulse rst_i mid-run -> all outputs 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a one-cycle bubble into EX and stalls PC/IF-ID on a load-use dependence.
module idex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic [4:0]        ID_rd,
  input  logic              ID_use_rt,
  input  logic [DATA_W-1:0] ID_data1,
  input  logic [DATA_W-1:0] ID_data2,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [7:0]        ID_ctrl,
  output logic [4:0]        IDEX_rs,
  output logic [4:0]        IDEX_rt,
  output logic [4:0]        IDEX_rd,
  output logic [DATA_W-1:0] IDEX_data1,
  output logic [DATA_W-1:0] IDEX_data2,
  output logic [DATA_W-1:0] IDEX_imm,
  output logic [7:0]        IDEX_ctrl,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int MEMREAD = 5;

  logic haz;
  logic rs_hit;
  logic rt_hit;
  logic cnt_full;

  assign rs_hit   = (IDEX_rt == ID_rs);
  assign rt_hit   = ID_use_rt && (IDEX_rt == ID_rt);
  assign haz      = IDEX_ctrl[MEMREAD] && (IDEX_rt != 5'd0)
                    && (rs_hit || rt_hit);
  assign stall_o  = haz | hold_i;
  assign cnt_full = &stall_cnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      IDEX_rs     <= '0;
      IDEX_rt     <= '0;
      IDEX_rd     <= '0;
      IDEX_data1  <= '0;
      IDEX_data2  <= '0;
      IDEX_imm    <= '0;
      IDEX_ctrl   <= '0;
      stall_cnt_o <= '0;
    end else if (hold_i) begin
      IDEX_ctrl   <= IDEX_ctrl;
    end else if (flush_i) begin
      // flush wins over a coincident hazard and is not counted
      IDEX_rs     <= ID_rs;
      IDEX_rt     <= ID_rt;
      IDEX_rd     <= ID_rd;
      IDEX_data1  <= ID_data1;
      IDEX_data2  <= ID_data2;
      IDEX_imm    <= ID_imm;
      IDEX_ctrl   <= '0;
    end else if (haz) begin
      IDEX_ctrl   <= '0;
      if (!cnt_full)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end else begin
      IDEX_rs     <= ID_rs;
      IDEX_rt     <= ID_rt;
      IDEX_rd     <= ID_rd;
      IDEX_data1  <= ID_data1;
      IDEX_data2  <= ID_data2;
      IDEX_imm    <= ID_imm;
      IDEX_ctrl   <= ID_ctrl;
    end
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Bench for idex_hazard_reg: directed vectors, queue scoreboard,
// negedge monitor; a CNT_W=2 copy shares the stimulus.
module tb_idex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  ID_rs = '0, ID_rt = '0, ID_rd = '0;
  logic        ID_use_rt = 1'b0;
  logic [31:0] ID_data1 = '0, ID_data2 = '0, ID_imm = '0;
  logic [7:0]  ID_ctrl = '0;

  logic [4:0]  IDEX_rs, IDEX_rt, IDEX_rd;
  logic [31:0] IDEX_data1, IDEX_data2, IDEX_imm;
  logic [7:0]  IDEX_ctrl;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_data1, s_data2, s_imm;
  logic [7:0]  s_ctrl;
  logic        s_stall;
  logic [1:0]  s_cnt;

  localparam logic [7:0] LW   = 8'hE8;
  localparam logic [7:0] ADD  = 8'h86;
  localparam logic [7:0] SW   = 8'h18;
  localparam logic [7:0] ADDI = 8'h88;
  localparam logic [7:0] NOP  = 8'h00;

  always #5 clk = ~clk;

  idex_hazard_reg #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_use_rt(ID_use_rt),
    .ID_data1(ID_data1), .ID_data2(ID_data2), .ID_imm(ID_imm),
    .ID_ctrl(ID_ctrl),
    .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt), .IDEX_rd(IDEX_rd),
    .IDEX_data1(IDEX_data1), .IDEX_data2(IDEX_data2),
    .IDEX_imm(IDEX_imm), .IDEX_ctrl(IDEX_ctrl),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  idex_hazard_reg #(.DATA_W(32), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_use_rt(ID_use_rt),
    .ID_data1(ID_data1), .ID_data2(ID_data2), .ID_imm(ID_imm),
    .ID_ctrl(ID_ctrl),
    .IDEX_rs(s_rs), .IDEX_rt(s_rt), .IDEX_rd(s_rd),
    .IDEX_data1(s_data1), .IDEX_data2(s_data2),
    .IDEX_imm(s_imm), .IDEX_ctrl(s_ctrl),
    .stall_o(s_stall), .stall_cnt_o(s_cnt)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
    logic        stall;
    int          cnt;
    int          cnt2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input string f,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", n, f, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "rs", 32'(IDEX_rs), 32'(e.rs));
      chk(e.name, "rt", 32'(IDEX_rt), 32'(e.rt));
      chk(e.name, "rd", 32'(IDEX_rd), 32'(e.rd));
      chk(e.name, "data1", IDEX_data1, e.d1);
      chk(e.name, "data2", IDEX_data2, e.d2);
      chk(e.name, "imm", IDEX_imm, e.imm);
      chk(e.name, "ctrl", 32'(IDEX_ctrl), 32'(e.ctrl));
      chk(e.name, "stall", 32'(stall_o), 32'(e.stall));
      chk(e.name, "cnt", 32'(stall_cnt_o), 32'(e.cnt));
      chk(e.name, "cnt_sat", 32'(s_cnt), 32'(e.cnt2));
      chk(e.name, "ctrl_sat", 32'(s_ctrl), 32'(e.ctrl));
      chk(e.name, "stall_sat", 32'(s_stall), 32'(e.stall));
    end
  end

  task automatic ap(input logic h, input logic f,
                    input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd, input logic urt,
                    input logic [31:0] d1, input logic [31:0] d2,
                    input logic [31:0] im, input logic [7:0] c);
    @(posedge clk);
    #1;
    hold_i = h; flush_i = f;
    ID_rs = rs; ID_rt = rt; ID_rd = rd; ID_use_rt = urt;
    ID_data1 = d1; ID_data2 = d2; ID_imm = im; ID_ctrl = c;
  endtask

  task automatic ex(input string n,
                    input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd,
                    input logic [31:0] d1, input logic [31:0] d2,
                    input logic [31:0] im, input logic [7:0] c,
                    input logic st, input int cnt, input int cnt2);
    exp_t e;
    e.name = n; e.rs = rs; e.rt = rt; e.rd = rd;
    e.d1 = d1; e.d2 = d2; e.imm = im; e.ctrl = c;
    e.stall = st; e.cnt = cnt; e.cnt2 = cnt2;
    sb.push_back(e);
  endtask

  initial begin
    // reset held from time 0
    ap(0,0, 0,0,0,0, 0,0,0, NOP);
    ex("reset", 0,0,0, 0,0,0, NOP, 0, 0,0);
    // lw $2,0($1)
    ap(0,0, 1,2,0,0, 100,7,0, LW);
    rst_i = 1'b0;
    ex("lw_id", 0,0,0, 0,0,0, NOP, 0, 0,0);
    // add $3,$2,$4 -> stall
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    ex("lu_stall", 1,2,0, 100,7,0, LW, 1, 0,0);
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    ex("bubble", 1,2,0, 100,7,0, NOP, 0, 1,1);
    ap(0,0, 0,0,0,0, 0,0,0, NOP);
    ex("add_ex", 2,4,3, 11,22,0, ADD, 0, 1,1);
    // lw $0 then add using $0: no hazard
    ap(0,0, 1,0,0,0, 100,0,0, LW);
    ex("nop", 0,0,0, 0,0,0, NOP, 0, 1,1);
    ap(0,0, 0,4,3,1, 0,22,0, ADD);
    ex("r0_nohaz", 1,0,0, 100,0,0, LW, 0, 1,1);
    // lw $5,4($9); sw $6,0($5) with use_rt=0
    ap(0,0, 9,5,0,0, 900,55,4, LW);
    ex("add_r0", 0,4,3, 0,22,0, ADD, 0, 1,1);
    ap(0,0, 5,6,0,0, 500,66,0, SW);
    ex("sw_rs", 9,5,0, 900,55,4, LW, 1, 1,1);
    // lw $5 again; addi with rt=5 but use_rt=0
    ap(0,0, 9,5,0,0, 900,55,4, LW);
    ex("bubble2", 9,5,0, 900,55,4, NOP, 0, 2,2);
    ap(0,0, 8,5,0,0, 800,555,1, ADDI);
    ex("addi_nohaz", 9,5,0, 900,55,4, LW, 0, 2,2);
    ap(0,0, 1,2,0,0, 100,7,0, LW);
    ex("addi_ex", 8,5,0, 800,555,1, ADDI, 0, 2,2);
    // hazard coincident with flush
    ap(0,1, 2,4,3,1, 11,22,0, ADD);
    ex("flush_haz", 1,2,0, 100,7,0, LW, 1, 2,2);
    ap(0,0, 1,2,0,0, 100,7,0, LW);
    ex("flush_bub", 2,4,3, 11,22,0, NOP, 0, 2,2);
    // hazard under hold
    ap(1,0, 2,4,3,1, 11,22,0, ADD);
    ex("hold_haz", 1,2,0, 100,7,0, LW, 1, 2,2);
    ap(1,0, 2,4,3,1, 11,22,0, ADD);
    ex("hold_keep", 1,2,0, 100,7,0, LW, 1, 2,2);
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    ex("hold_drop", 1,2,0, 100,7,0, LW, 1, 2,2);
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    ex("hold_bub", 1,2,0, 100,7,0, NOP, 0, 3,3);
    // two more hazards: CNT_W=2 copy saturates at 3
    ap(0,0, 1,2,0,0, 100,7,0, LW);
    ex("add3", 2,4,3, 11,22,0, ADD, 0, 3,3);
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    ex("haz4", 1,2,0, 100,7,0, LW, 1, 3,3);
    ap(0,0, 1,2,0,0, 100,7,0, LW);
    ex("sat4", 1,2,0, 100,7,0, NOP, 0, 4,3);
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    ex("haz5", 1,2,0, 100,7,0, LW, 1, 4,3);
    ap(0,0, 1,2,0,0, 100,7,0, LW);
    ex("sat5", 1,2,0, 100,7,0, NOP, 0, 5,3);
    // stall pending, then async reset with no edge before the check
    ap(1,0, 2,4,3,1, 11,22,0, ADD);
    ex("pre_rst", 1,2,0, 100,7,0, LW, 1, 5,3);
    ap(0,0, 2,4,3,1, 11,22,0, ADD);
    rst_i = 1'b1;
    ex("async_rst", 0,0,0, 0,0,0, NOP, 0, 0,0);
    ap(1,0, 2,4,3,1, 11,22,0, ADD);
    rst_i = 1'b0;
    ex("hold_only", 0,0,0, 0,0,0, NOP, 1, 0,0);
    ap(0,0, 0,0,0,0, 0,0,0, NOP);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
